// File: rtl/music_sequencer_ctrl.sv
// music_sequencer_ctrl: tempo divider and step counter addressing the song note
// tables, with a one-shot sound-effect overlay that pre-empts music on note_out.
`default_nettype none

module music_sequencer_ctrl #(
  parameter int TEMPO_DIV = 10000000,
  parameter int NUM_STEPS = 128,
  parameter int REST_CODE = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] song_sel,
  output logic [1:0] rom_song,
  output logic [6:0] rom_step,
  input  logic [4:0] rom_note,
  input  logic       sfx_req,
  input  logic [4:0] sfx_note,
  input  logic [3:0] sfx_steps,
  output logic       sfx_ack,
  output logic [4:0] note_out,
  output logic       playing,
  output logic       step_tick,
  output logic       done
);

  localparam int TICK_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;

  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TEMPO_DIV - 1);
  localparam logic [TICK_W-1:0] c_tick_zero = '0;
  localparam logic [TICK_W-1:0] c_tick_one  = TICK_W'(1);
  localparam logic [6:0]        c_step_last = 7'(NUM_STEPS - 1);
  localparam logic [4:0]        c_rest_note = 5'(REST_CODE);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_play = 1'b1;

  logic [0:0]        state_q,      state_d;
  logic [1:0]        rom_song_q,   rom_song_d;
  logic [6:0]        rom_step_q,   rom_step_d;
  logic [TICK_W-1:0] tick_q,       tick_d;
  logic              sfx_active_q, sfx_active_d;
  logic [3:0]        sfx_left_q,   sfx_left_d;
  logic [4:0]        sfx_note_q,   sfx_note_d;
  logic [4:0]        note_out_q,   note_out_d;
  logic              step_tick_q,  step_tick_d;
  logic              done_q,       done_d;
  logic              sfx_ack_q,    sfx_ack_d;

  logic              w_running;
  logic              w_wrap;
  logic              w_play_acc;
  logic              w_sfx_acc;
  logic [3:0]        w_sfx_len;

  always_comb begin
    w_running  = (state_q == c_play) || sfx_active_q;
    w_wrap     = w_running && (tick_q == c_tick_last);
    w_play_acc = play && !stop;
    w_sfx_acc  = sfx_req && !sfx_active_q;
    w_sfx_len  = (sfx_steps == 4'd0) ? 4'd1 : sfx_steps;

    state_d      = state_q;
    rom_song_d   = rom_song_q;
    rom_step_d   = rom_step_q;
    sfx_active_d = sfx_active_q;
    sfx_left_d   = sfx_left_q;
    sfx_note_d   = sfx_note_q;
    done_d       = 1'b0;
    step_tick_d  = w_wrap;
    sfx_ack_d    = w_sfx_acc;

    // An effect starting from silence gets a full first step; during music it
    // stays locked to the running song phase.
    if (w_play_acc) begin
      tick_d = c_tick_zero;
    end else if (w_sfx_acc && (state_q == c_idle)) begin
      tick_d = c_tick_zero;
    end else if (w_running) begin
      tick_d = w_wrap ? c_tick_zero : (tick_q + c_tick_one);
    end else begin
      tick_d = c_tick_zero;
    end

    if (stop) begin
      state_d = c_idle;
    end else if (play) begin
      state_d    = c_play;
      rom_song_d = song_sel;
      rom_step_d = 7'd0;
    end else if ((state_q == c_play) && w_wrap) begin
      if (rom_step_q < c_step_last) begin
        rom_step_d = rom_step_q + 7'd1;
      end else if (loop_en) begin
        rom_step_d = 7'd0;
      end else begin
        state_d    = c_idle;
        rom_step_d = 7'd0;
        done_d     = 1'b1;
      end
    end

    if (w_sfx_acc) begin
      sfx_active_d = 1'b1;
      sfx_note_d   = sfx_note;
      sfx_left_d   = w_sfx_len;
    end else if (sfx_active_q && w_wrap) begin
      sfx_left_d = sfx_left_q - 4'd1;
      if (sfx_left_q == 4'd1) begin
        sfx_active_d = 1'b0;
      end
    end

    if (sfx_active_q) begin
      note_out_d = sfx_note_q;
    end else if (state_q == c_play) begin
      note_out_d = rom_note;
    end else begin
      note_out_d = c_rest_note;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_idle;
      rom_song_q   <= 2'd0;
      rom_step_q   <= 7'd0;
      tick_q       <= c_tick_zero;
      sfx_active_q <= 1'b0;
      sfx_left_q   <= 4'd0;
      sfx_note_q   <= 5'd0;
      note_out_q   <= c_rest_note;
      step_tick_q  <= 1'b0;
      done_q       <= 1'b0;
      sfx_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_song_q   <= rom_song_d;
      rom_step_q   <= rom_step_d;
      tick_q       <= tick_d;
      sfx_active_q <= sfx_active_d;
      sfx_left_q   <= sfx_left_d;
      sfx_note_q   <= sfx_note_d;
      note_out_q   <= note_out_d;
      step_tick_q  <= step_tick_d;
      done_q       <= done_d;
      sfx_ack_q    <= sfx_ack_d;
    end
  end

  assign rom_song  = rom_song_q;
  assign rom_step  = rom_step_q;
  assign note_out  = note_out_q;
  assign playing   = (state_q == c_play);
  assign step_tick = step_tick_q;
  assign done      = done_q;
  assign sfx_ack   = sfx_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_music_sequencer_ctrl.sv
// Randomized and directed bench for music_sequencer_ctrl against a cycle-level
// behavioural model of the playback rules.
`default_nettype none

module tb_music_sequencer_ctrl;

  localparam int T     = 4;
  localparam int STEPS = 128;
  localparam int REST  = 25;

  logic       clk = 1'b0;
  logic       rst, play, stop, loop_en, sfx_req;
  logic [1:0] song_sel;
  logic [4:0] sfx_note;
  logic [3:0] sfx_steps;
  logic [1:0] rom_song;
  logic [6:0] rom_step;
  logic [4:0] rom_note;
  logic       sfx_ack, playing, step_tick, done;
  logic [4:0] note_out;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  music_sequencer_ctrl #(.TEMPO_DIV(T), .NUM_STEPS(STEPS), .REST_CODE(REST)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .loop_en(loop_en),
    .song_sel(song_sel), .rom_song(rom_song), .rom_step(rom_step),
    .rom_note(rom_note), .sfx_req(sfx_req), .sfx_note(sfx_note),
    .sfx_steps(sfx_steps), .sfx_ack(sfx_ack), .note_out(note_out),
    .playing(playing), .step_tick(step_tick), .done(done)
  );

  function automatic logic [4:0] tbl(input logic [1:0] s, input logic [6:0] p);
    int v;
    v = (int'(s) * 37 + int'(p) * 11 + int'(p >> 3)) % 26;
    return 5'(v);
  endfunction

  always_comb rom_note = tbl(rom_song, rom_step);

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: whole-song view with a phase counter inside the current step.
  bit       m_play, m_fx;
  int       m_song, m_step, m_cnt, m_fx_left, m_fx_note;
  int       e_note;
  bit       e_tick, e_done, e_ack;
  bit       bnd, acc;

  always @(posedge clk) begin
    if (rst) begin
      m_play = 0; m_fx = 0; m_song = 0; m_step = 0; m_cnt = 0;
      m_fx_left = 0; m_fx_note = 0;
      e_note = REST; e_tick = 0; e_done = 0; e_ack = 0;
    end else begin
      bnd = (m_play || m_fx) && (m_cnt == T - 1);
      acc = sfx_req && !m_fx;
      e_note = m_fx ? m_fx_note : (m_play ? int'(tbl(2'(m_song), 7'(m_step))) : REST);
      e_tick = bnd;
      e_ack  = acc;
      e_done = m_play && !stop && !play && bnd && (m_step == STEPS - 1) && !loop_en;

      if (play && !stop)           m_cnt = 0;
      else if (acc && !m_play)     m_cnt = 0;
      else if (m_play || m_fx)     m_cnt = (m_cnt + 1) % T;
      else                         m_cnt = 0;

      if (stop) m_play = 0;
      else if (play) begin
        m_play = 1; m_song = int'(song_sel); m_step = 0;
      end else if (m_play && bnd) begin
        if (m_step + 1 < STEPS) m_step = m_step + 1;
        else begin
          m_step = 0;
          if (!loop_en) m_play = 0;
        end
      end

      if (acc) begin
        m_fx = 1; m_fx_note = int'(sfx_note);
        m_fx_left = (sfx_steps == 0) ? 1 : int'(sfx_steps);
      end else if (m_fx && bnd) begin
        m_fx_left = m_fx_left - 1;
        if (m_fx_left == 0) m_fx = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("note_out",  note_out,  e_note);
      check("playing",   playing,   m_play);
      check("rom_step",  rom_step,  m_step);
      check("rom_song",  rom_song,  m_song);
      check("step_tick", step_tick, e_tick);
      check("done",      done,      e_done);
      check("sfx_ack",   sfx_ack,   e_ack);
    end
  end

  int cnt, nacc, n12, prev;
  bit found;

  initial begin
    rst = 1; play = 0; stop = 0; loop_en = 0; song_sel = 0;
    sfx_req = 0; sfx_note = 0; sfx_steps = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst = 0;

    // Idle after reset
    cnt = 0;
    repeat (20) begin @(negedge clk); if (step_tick) cnt++; end
    check("idle_ticks", cnt, 0);
    check("idle_note", note_out, 25);
    check("idle_playing", playing, 0);

    // Non-looping song 1
    song_sel = 2'd1; play = 1; @(negedge clk); play = 0;
    check("song1_rom_song", rom_song, 1);
    check("song1_start_step", rom_step, 0);
    cnt = 0; found = 0;
    for (int i = 0; i < 700; i++) begin
      if (done) begin found = 1; break; end
      @(negedge clk); cnt++;
    end
    check("song1_done_seen", found, 1);
    check("song1_done_cycles", cnt, 512);
    @(negedge clk);
    check("song1_after_done", done, 0);
    check("song1_rest_note", note_out, 25);
    check("song1_idle", playing, 0);

    // Looping song 3
    loop_en = 1; song_sel = 2'd3; play = 1; @(negedge clk); play = 0;
    nacc = 0; n12 = 0; prev = rom_step;
    repeat (540) begin
      @(negedge clk);
      if (done) nacc++;
      if (prev == 127 && rom_step == 0 && playing) n12++;
      prev = rom_step;
    end
    check("loop_no_done", nacc, 0);
    check("loop_wraps", n12, 1);
    stop = 1; @(negedge clk); stop = 0; loop_en = 0;
    check("stop_idle", playing, 0);

    // Effect during song 0 at step 10
    song_sel = 2'd0; play = 1; @(negedge clk); play = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (rom_step == 10) begin found = 1; break; end
      @(negedge clk);
    end
    check("fx_reach_step10", found, 1);
    sfx_note = 5'd12; sfx_steps = 4'd3; sfx_req = 1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sfx_ack) begin found = 1; break; end
    end
    sfx_req = 0;
    check("fx_ack_seen", found, 1);
    @(negedge clk);
    check("fx_note_on", note_out, 12);
    nacc = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      if (sfx_ack) nacc++;
      if (note_out != 12) begin found = 1; break; end
      @(negedge clk);
    end
    check("fx_ended", found, 1);
    check("fx_resume_step", rom_step, 13);
    check("fx_resume_note", note_out, 14);
    check("fx_extra_ack", nacc, 0);
    stop = 1; @(negedge clk); stop = 0;

    // Zero-length effect from idle plus an ignored second request
    repeat (3) @(negedge clk);
    sfx_note = 5'd12; sfx_steps = 4'd0; sfx_req = 1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sfx_ack) begin found = 1; break; end
    end
    sfx_req = 0;
    check("fx0_ack_seen", found, 1);
    nacc = 1; n12 = 0;
    for (int i = 0; i < 12; i++) begin
      sfx_req = (i == 1 || i == 2);
      @(negedge clk);
      if (sfx_ack) nacc++;
      if (note_out == 12) n12++;
    end
    sfx_req = 0;
    check("fx0_ack_count", nacc, 1);
    check("fx0_note_cycles", n12, 4);

    // play+stop together, restart with new song, reset mid-effect
    play = 1; stop = 1; @(negedge clk); play = 0; stop = 0;
    check("playstop_idle", playing, 0);
    song_sel = 2'd0; play = 1; @(negedge clk); play = 0;
    repeat (30) @(negedge clk);
    song_sel = 2'd2; play = 1; @(negedge clk); play = 0;
    check("restart_song", rom_song, 2);
    check("restart_step", rom_step, 0);
    check("restart_playing", playing, 1);
    sfx_steps = 4'd5; sfx_req = 1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sfx_ack) begin found = 1; break; end
    end
    sfx_req = 0;
    check("rstfx_ack_seen", found, 1);
    repeat (3) @(negedge clk);
    rst = 1; @(negedge clk);
    check("rst_note", note_out, 25);
    check("rst_playing", playing, 0);
    check("rst_step", rom_step, 0);
    check("rst_song", rom_song, 0);
    check("rst_ack", sfx_ack, 0);
    rst = 0;
    repeat (8) @(negedge clk);
    check("rst_fx_cleared", note_out, 25);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      play      = ($urandom % 60) == 0;
      stop      = ($urandom % 90) == 0;
      rst       = ($urandom % 700) == 0;
      song_sel  = 2'($urandom);
      if (($urandom % 200) == 0) loop_en = ~loop_en;
      sfx_req   = ($urandom % 25) == 0;
      sfx_note  = 5'($urandom);
      sfx_steps = 4'($urandom % 4);
      @(negedge clk);
    end
    play = 0; stop = 0; rst = 0; sfx_req = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
